// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_serial_adder
// Description : Multi-cycle adder, CHUNK bits per clock with a registered
//               carry ripple. CHUNKED_SERIAL_ADDER_OVERFLOW_EN adds overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
`ifdef CHUNKED_SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;

    int                w_base;
    logic [CHUNK-1:0]  w_slice_a;
    logic [CHUNK-1:0]  w_slice_b;
    logic [CHUNK:0]    w_add;
    logic              w_accept;
    logic              w_last;

    assign w_base    = int'(r_idx) * CHUNK;
    assign w_slice_a = r_a[w_base +: CHUNK];
    assign w_slice_b = r_b[w_base +: CHUNK];
    assign w_add     = {1'b0, w_slice_a} + {1'b0, w_slice_b} + {{CHUNK{1'b0}}, r_carry};
    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_idx == c_last_idx);

`ifdef CHUNKED_SERIAL_ADDER_OVERFLOW_EN
    // Carry into the MSB is recovered as sum_msb ^ a_msb ^ b_msb.
    logic w_ovf;
    assign w_ovf = w_add[CHUNK] ^ w_add[CHUNK-1] ^ w_slice_a[CHUNK-1] ^ w_slice_b[CHUNK-1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            sum      <= '0;
            carryOut <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= carryIn;
                        sum     <= '0;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
`ifdef CHUNKED_SERIAL_ADDER_OVERFLOW_EN
                        overflow <= 1'b0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum[w_base +: CHUNK] <= w_add[CHUNK-1:0];
                    r_carry              <= w_add[CHUNK];
                    r_idx                <= r_idx + 1'b1;
                    if (w_last) begin
                        carryOut <= w_add[CHUNK];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
`ifdef CHUNKED_SERIAL_ADDER_OVERFLOW_EN
                        overflow <= w_ovf;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle adder; successor to the single-cycle 4-bit parallel adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, rippling the carry between chunks in a register.
- Trades latency for a narrow carry chain.
- Datapath helper wherever wide additions must meet timing with a small adder; start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits.
- CHUNK, 2, bits added per cycle. WIDTH must be an integer multiple of CHUNK.
- NCHUNK (localparam), WIDTH/CHUNK, cycles per addition.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block can accept.
- a  input  WIDTH  operand A, captured on the accepted start.
- b  input  WIDTH  operand B, captured on the accepted start.
- carryIn  input  1  carry-in, captured on the accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse: sum/carryOut valid.
- sum  output  WIDTH  registered result, held until the next accepted start.
- carryOut  output  1  registered final carry, held with sum.

Behaviour:
- States: IDLE, RUN, DONE. Chunk index counter idx, width clog2(NCHUNK), min 1 bit.
- Reset (synchronous; takes priority over everything):
  - state=IDLE, idx=0.
  - sum=0, carryOut=0, busy=0, done=0.
  - Internal operand and carry registers = 0.
- Accept: start=1 while state is IDLE or DONE.
  - Captures a, b, carryIn into internal registers.
  - Clears sum to 0, idx=0, state→RUN, busy=1 from the next cycle.
- RUN, each edge:
  - Slice k=idx covers bits [k*CHUNK +: CHUNK].
  - Compute sliceA + sliceB + carry reg (CHUNK+1 bits).
  - Write low CHUNK bits into the same slice of sum; store the MSB into the carry reg.
  - idx increments.
  - On the edge processing idx=NCHUNK-1: carryOut=final carry, state→DONE, busy=0, done=1.
- DONE: lasts exactly one cycle; done=1, then state→IDLE with done=0 unless a new start is accepted.
- Latency: start sampled at edge E0 → done high in the cycle after edge E0+NCHUNK. Default config: done 4 cycles after accept.
- Throughput: back-to-back start in the DONE cycle is accepted, giving one result per NCHUNK+1 cycles.
- start during RUN: ignored; no effect on operands, idx or outputs.
- sum during RUN: partially written and must not be consumed. sum and carryOut are defined only from done until the next accept.
- CHUNK=WIDTH: NCHUNK=1, single RUN cycle, same protocol.
- Arithmetic is unsigned modulo 2^WIDTH; carryOut is bit WIDTH of a+b+carryIn.
- Operand inputs may change freely after accept; only the captured copies are used.
- Reset mid-RUN: aborts the addition. The next cycle is IDLE with all outputs 0, and no done pulse is generated.

Optional Feature:
- Macro: CHUNKED_SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit, registered).
  - Set with carryOut on the final chunk to carry-into-MSB XOR carry-out-of-MSB, i.e. signed two's-complement overflow.
  - Held with sum; reset value 0; cleared to 0 on accept.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic: WIDTH=8, CHUNK=2; a=0x05, b=0x04, carryIn=1, start pulse → busy 4 cycles, done 1 cycle, sum=0x0A, carryOut=0.
- Full ripple: a=0xFF, b=0x01, carryIn=0 → sum=0x00, carryOut=1. Also a=0xFF, b=0xFF, carryIn=1 → sum=0xFF, carryOut=1.
- Start while busy: accept a=0x10, b=0x20; assert start with a=0xAA, b=0x55 in RUN cycle 2 → result sum=0x30, carryOut=0, single done pulse.
- Back-to-back: start held high across DONE with a second operand pair 0x3C+0x0F, cin=0 → first done then second done NCHUNK+1 cycles later, sum=0x4B.
- Reset mid-operation: reset in RUN cycle 2 → next cycle busy=0, done=0, sum=0, carryOut=0, no done pulse; a following 0x01+0x01 gives sum=0x02.
- Overflow (macro defined): 0x7F+0x01, cin=0 → sum=0x80, overflow=1, carryOut=0. 0x80+0x80 → sum=0x00, overflow=1, carryOut=1. Macro undefined: the same vectors give the same sum/carryOut.
